sram_march_bist: RTL and testbench

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

---
 rtl/sram_bist_pkg.sv | 43 ++++
 rtl/sram_bist_addr_gen.sv | 31 +++
 rtl/sram_march_bist.sv | 194 +++++++++++++++++++
 tb/tb_sram_march_bist.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM BIST.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned NUM_ELEM = 6;

    // One march element: sweep direction, optional read (expected value) and
    // optional write (written value). Values are whole-word all-zeros/all-ones.
    typedef struct packed {
        logic down;
        logic has_rd;
        logic rd_one;
        logic has_wr;
        logic wr_one;
    } elem_t;

    // Only E3 and E4 sweep downwards.
    function automatic logic elem_down(input logic [2:0] idx);
        return (idx == 3'd3) || (idx == 3'd4);
    endfunction

    function automatic elem_t elem_cfg(input logic [2:0] idx);
        elem_t e;
        e.down = elem_down(idx);
        case (idx)
            3'd0:    begin e.has_rd = 1'b0; e.rd_one = 1'b0; e.has_wr = 1'b1; e.wr_one = 1'b0; end
            3'd1:    begin e.has_rd = 1'b1; e.rd_one = 1'b0; e.has_wr = 1'b1; e.wr_one = 1'b1; end
            3'd2:    begin e.has_rd = 1'b1; e.rd_one = 1'b1; e.has_wr = 1'b1; e.wr_one = 1'b0; end
            3'd3:    begin e.has_rd = 1'b1; e.rd_one = 1'b0; e.has_wr = 1'b1; e.wr_one = 1'b1; end
            3'd4:    begin e.has_rd = 1'b1; e.rd_one = 1'b1; e.has_wr = 1'b1; e.wr_one = 1'b0; end
            3'd5:    begin e.has_rd = 1'b1; e.rd_one = 1'b0; e.has_wr = 1'b0; e.wr_one = 1'b0; end
            default: begin e.has_rd = 1'b0; e.rd_one = 1'b0; e.has_wr = 1'b0; e.wr_one = 1'b0; end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for the march sweeps, with a last-address flag.
module sram_bist_addr_gen #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,       // load the start address of a sweep
    input  logic              init_down,  // direction of the sweep being loaded
    input  logic              step,       // advance in the current direction
    input  logic              down,       // current sweep direction
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] TopAddr = ADDR_W'(DEPTH - 1);

    // Address register: load takes priority over step.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (init) begin
            addr <= init_down ? TopAddr : '0;
        end else if (step) begin
            addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
    end

    assign last = down ? (addr == '0) : (addr == TopAddr);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller with functional passthrough to a single-port SRAM.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              usr_csb0,
    input  logic              usr_web0,
    input  logic [ADDR_W-1:0] usr_addr0,
    input  logic [DATA_W-1:0] usr_din0,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [7:0]        err_count
);

    state_e            state_q;
    logic [2:0]        elem_q;
    logic              phase_q;  // 0: first op at this address, 1: write after read
    logic [7:0]        drain_q;
    logic              busy_q, done_q, pass_q;
    logic [7:0]        err_q, err_d;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q;

    // Compare pipeline: one slot per cycle of read latency.
    logic [RD_LAT-1:0]             pv_q;
    logic [RD_LAT-1:0][DATA_W-1:0] pe_q;
    logic [RD_LAT-1:0][ADDR_W-1:0] pa_q;

    elem_t             cur;
    logic              run, start_go, rd_op, addr_done, last_elem, mismatch;
    logic              ag_init, ag_init_down, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr;

    assign cur       = elem_cfg(elem_q);
    assign run       = (state_q == StRun);
    assign start_go  = (state_q == StIdle) && start;
    assign rd_op     = cur.has_rd && !phase_q;
    // An address is finished once its last op (read-only, write-only or the write) issues.
    assign addr_done = !(cur.has_rd && cur.has_wr && !phase_q);
    assign last_elem = (elem_q == 3'(NUM_ELEM - 1));

    assign ag_init      = start_go || (run && addr_done && ag_last && !last_elem);
    assign ag_init_down = (state_q == StIdle) ? 1'b0 : elem_down(elem_q + 3'd1);
    assign ag_step      = run && addr_done && !ag_last;

    sram_bist_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .init      (ag_init),
        .init_down (ag_init_down),
        .step      (ag_step),
        .down      (cur.down),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    assign mismatch = pv_q[RD_LAT-1] && (dout0 != pe_q[RD_LAT-1]);
    assign err_d    = (mismatch && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

    // Shift each issued read's expected data and address along with the SRAM latency.
    always_ff @(posedge clk) begin
        if (rst || start_go) begin
            pv_q <= '0;
            pe_q <= '0;
            pa_q <= '0;
        end else begin
            pv_q[0] <= run && rd_op;
            pe_q[0] <= {DATA_W{cur.rd_one}};
            pa_q[0] <= ag_addr;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
        end
    end

    // Control FSM with registered status outputs and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            elem_q      <= '0;
            phase_q     <= 1'b0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            err_q <= err_d;
            if (mismatch && (err_q == '0)) begin
                fail_addr_q <= pa_q[RD_LAT-1];
                fail_data_q <= dout0;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StRun;
                        busy_q      <= 1'b1;
                        elem_q      <= '0;
                        phase_q     <= 1'b0;
                        pass_q      <= 1'b0;
                        err_q       <= '0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                    end
                end
                StRun: begin
                    if (addr_done) begin
                        phase_q <= 1'b0;
                        if (ag_last) begin
                            if (last_elem) begin
                                state_q <= StDrain;
                                drain_q <= '0;
                            end else begin
                                elem_q <= elem_q + 3'd1;
                            end
                        end
                    end else begin
                        phase_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (drain_q == 8'(RD_LAT - 1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // err_d includes the final read compared in this cycle.
                        pass_q  <= (err_d == '0);
                    end else begin
                        drain_q <= drain_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // SRAM port mux: user passthrough in IDLE/DONE, march ops in RUN, quiet in DRAIN.
    always_comb begin
        csb0  = usr_csb0;
        web0  = usr_web0;
        addr0 = usr_addr0;
        din0  = usr_din0;
        case (state_q)
            StRun: begin
                csb0  = 1'b0;
                web0  = rd_op;
                addr0 = ag_addr;
                din0  = {DATA_W{cur.wr_one}};
            end
            StDrain: begin
                csb0  = 1'b1;
                web0  = 1'b1;
                addr0 = ag_addr;
                din0  = '0;
            end
            default: ;
        endcase
        if (rst) csb0 = 1'b1;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench for sram_march_bist with a fault-injectable SRAM model.
module tb_sram_march_bist;

    localparam int DEPTH = 512;

    logic       clk = 1'b0;
    logic       rst, start, usr_csb0, usr_web0;
    logic [8:0] usr_addr0;
    logic [7:0] usr_din0;
    logic       csb0, web0;
    logic [8:0] addr0;
    logic [7:0] din0, dout0;
    logic       busy, done, pass;
    logic [8:0] fail_addr;
    logic [7:0] fail_data, err_count;

    int checks = 0;
    int errors = 0;

    // Fault config: kind 0 none, 1 stuck bits at f_addr, 2 writes to 1 also hit 0.
    int         f_kind = 0;
    logic [8:0] f_addr = '0;
    logic [7:0] f_mask = '0;
    logic       f_sval = 1'b0;
    logic [7:0] mem [DEPTH];

    sram_march_bist dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .usr_csb0  (usr_csb0),
        .usr_web0  (usr_web0),
        .usr_addr0 (usr_addr0),
        .usr_din0  (usr_din0),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] apply_fault(input int kind, input logic [8:0] fa,
                                               input logic [7:0] mask, input logic sv,
                                               input logic [8:0] a, input logic [7:0] d);
        if (kind == 1 && a == fa) return sv ? (d | mask) : (d & ~mask);
        return d;
    endfunction

    // SRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                mem[addr0] <= din0;
                if (f_kind == 2 && addr0 == 9'd1) mem[0] <= din0;
            end else begin
                dout0 <= apply_fault(f_kind, f_addr, f_mask, f_sval, addr0, mem[addr0]);
            end
        end
    end

    // Reference: walk the March C- element list over a plain array.
    function automatic void march_model(input int kind, input logic [8:0] fa_in,
                                        input logic [7:0] mask, input logic sv,
                                        output int errs, output logic [8:0] fa,
                                        output logic [7:0] fd);
        logic [7:0] m [DEPTH];
        int         rd_v [6];
        int         wr_v [6];
        bit         dn [6];
        int         a;
        logic [7:0] v, expv;
        rd_v = '{-1, 0, 1, 0, 1, 0};
        wr_v = '{0, 1, 0, 1, 0, -1};
        dn   = '{0, 0, 0, 1, 1, 0};
        errs = 0; fa = '0; fd = '0;
        for (int i = 0; i < DEPTH; i++) m[i] = 8'h5A;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = dn[e] ? DEPTH - 1 - i : i;
                if (rd_v[e] >= 0) begin
                    v    = apply_fault(kind, fa_in, mask, sv, 9'(a), m[a]);
                    expv = (rd_v[e] == 1) ? 8'hFF : 8'h00;
                    if (v !== expv) begin
                        if (errs == 0) begin fa = 9'(a); fd = v; end
                        if (errs < 255) errs++;
                    end
                end
                if (wr_v[e] >= 0) begin
                    m[a] = (wr_v[e] == 1) ? 8'hFF : 8'h00;
                    if (kind == 2 && a == 1) m[0] = m[a];
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Pulse start for one cycle and follow the test; usr_* is driven with junk throughout.
    task automatic do_run(output int done_at, output int busy_cnt, output int cmds);
        int n;
        usr_csb0 = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        done_at = 0; busy_cnt = 0; cmds = 0; n = 1;
        while (n <= 6000 && done_at == 0) begin
            usr_csb0  = 1'b0;
            usr_web0  = 1'($urandom_range(1, 0));
            usr_addr0 = 9'($urandom_range(511, 0));
            usr_din0  = 8'($urandom_range(255, 0));
            #1;
            if (busy) busy_cnt++;
            if (busy && !csb0) cmds++;
            if (done) done_at = n;
            @(negedge clk);
            n++;
        end
        usr_csb0 = 1'b1;
        usr_web0 = 1'b1;
    endtask

    typedef struct {
        int         kind;
        logic [8:0] faddr;
        logic [7:0] mask;
        logic       sval;
        logic       exp_pass;
        int         exp_err;
        logic [8:0] exp_fa;
        logic [7:0] exp_fd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at, busy_cnt, cmds, m_err, dcount, dn_at;
        logic [8:0] m_fa;
        logic [7:0] m_fd;
        logic b5123, b5124, seen;

        rst = 1'b1; start = 1'b0;
        usr_csb0 = 1'b0; usr_web0 = 1'b1; usr_addr0 = '0; usr_din0 = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(255, 0));
        repeat (3) @(negedge clk);
        chk("rst_csb0", csb0, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_fail_data", fail_data, 0);
        rst = 1'b0; usr_csb0 = 1'b1;

        // Vector table: fixed cases first, random stuck-at faults, known faults last.
        vecs[0] = '{kind: 0, faddr: 9'h0, mask: 8'h0, sval: 1'b0,
                    exp_pass: 1'b1, exp_err: 0, exp_fa: 9'h0, exp_fd: 8'h00};
        for (int i = 1; i <= 3; i++) begin
            vecs[i].kind  = 1;
            vecs[i].faddr = 9'($urandom_range(511, 0));
            vecs[i].mask  = 8'(1 << $urandom_range(7, 0));
            vecs[i].sval  = 1'($urandom_range(1, 0));
            march_model(1, vecs[i].faddr, vecs[i].mask, vecs[i].sval, m_err, m_fa, m_fd);
            vecs[i].exp_pass = (m_err == 0);
            vecs[i].exp_err  = m_err;
            vecs[i].exp_fa   = m_fa;
            vecs[i].exp_fd   = m_fd;
        end
        vecs[4] = '{kind: 1, faddr: 9'h0A5, mask: 8'h01, sval: 1'b1,
                    exp_pass: 1'b0, exp_err: 3, exp_fa: 9'h0A5, exp_fd: 8'h01};
        vecs[5] = '{kind: 2, faddr: 9'h0, mask: 8'h0, sval: 1'b0,
                    exp_pass: 1'b0, exp_err: 2, exp_fa: 9'h000, exp_fd: 8'hFF};

        for (int i = 0; i < 6; i++) begin
            f_kind = vecs[i].kind; f_addr = vecs[i].faddr;
            f_mask = vecs[i].mask; f_sval = vecs[i].sval;
            do_run(done_at, busy_cnt, cmds);
            chk($sformatf("v%0d_done_cycle", i), done_at, 5122);
            chk($sformatf("v%0d_busy_cycles", i), busy_cnt, 5121);
            chk($sformatf("v%0d_cmds", i), cmds, 5120);
            chk($sformatf("v%0d_done_low", i), done, 0);
            chk($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
            chk($sformatf("v%0d_err", i), err_count, vecs[i].exp_err);
            chk($sformatf("v%0d_fail_addr", i), fail_addr, vecs[i].exp_fa);
            chk($sformatf("v%0d_fail_data", i), fail_data, vecs[i].exp_fd);
        end

        // IDLE passthrough write then read.
        f_kind = 0;
        @(negedge clk);
        usr_csb0 = 1'b0; usr_web0 = 1'b0; usr_addr0 = 9'h1FF; usr_din0 = 8'h3C;
        #1;
        chk("pt_csb0", csb0, 0);
        chk("pt_web0", web0, 0);
        chk("pt_addr0", addr0, 9'h1FF);
        chk("pt_din0", din0, 8'h3C);
        @(negedge clk) begin usr_web0 = 1'b1; usr_din0 = 8'h00; end
        @(negedge clk) usr_csb0 = 1'b1;
        chk("pt_dout0", dout0, 8'h3C);
        chk("pt_busy", busy, 0);
        chk("pt_err", err_count, vecs[5].exp_err);
        chk("pt_pass_hold", pass, vecs[5].exp_pass);

        // Reset at RUN cycle 1000 aborts the test.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        usr_csb0 = 1'b0;
        repeat (999) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_rst_csb0", csb0, 1);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_idle_passthru", csb0, 0);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);
        do_run(done_at, busy_cnt, cmds);
        chk("restart_done_cycle", done_at, 5122);
        chk("restart_pass", pass, 1);
        chk("restart_err", err_count, 0);

        // start held high for 6000 cycles.
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        dcount = 0; dn_at = 0; b5123 = 1'bx; b5124 = 1'bx;
        for (int n = 1; n <= 6000; n++) begin
            if (done) begin
                dcount++;
                if (dn_at == 0) dn_at = n;
            end
            if (n == 5123) b5123 = busy;
            if (n == 5124) b5124 = busy;
            @(negedge clk);
        end
        start = 1'b0;
        chk("held_done_count", dcount, 1);
        chk("held_done_cycle", dn_at, 5122);
        chk("held_idle_5123", b5123, 0);
        chk("held_rerun_5124", b5124, 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
